// File: rtl/text_pkg.sv
// Shared geometry, character codes and state encoding for the text-mode writer.
package text_pkg;

  localparam int unsigned ROW_NUMBER     = 16;
  localparam int unsigned COL_NUMBER     = 32;
  localparam int unsigned ROW_BIT_LEN    = 4;
  localparam int unsigned COL_BIT_LEN    = 5;
  localparam int unsigned CHAR_ID_LENGTH = 8;
  localparam int unsigned ADDR_LEN       = ROW_BIT_LEN + COL_BIT_LEN;
  localparam int unsigned TOTAL_CHAR     = 129;

  typedef logic [ROW_BIT_LEN-1:0]    row_t;
  typedef logic [COL_BIT_LEN-1:0]    col_t;
  typedef logic [CHAR_ID_LENGTH-1:0] char_t;
  typedef logic [ADDR_LEN-1:0]       addr_t;

  localparam char_t BLANK_ID   = CHAR_ID_LENGTH'(32);
  localparam char_t CC_BS      = CHAR_ID_LENGTH'(8'h08);
  localparam char_t CC_LF      = CHAR_ID_LENGTH'(8'h0A);
  localparam char_t CC_FF      = CHAR_ID_LENGTH'(8'h0C);
  localparam char_t CC_CR      = CHAR_ID_LENGTH'(8'h0D);
  localparam char_t DRAW_LIMIT = CHAR_ID_LENGTH'(TOTAL_CHAR);

  typedef enum logic [1:0] {
    CLEAR_ALL = 2'd0,
    CLEAR_ROW = 2'd1,
    IDLE      = 2'd2
  } state_t;

  // Drawable glyph that is not one of the handled control codes.
  function automatic logic is_printable(input char_t c);
    return (c < DRAW_LIMIT) && (c != CC_BS) && (c != CC_LF) &&
           (c != CC_FF) && (c != CC_CR);
  endfunction

endpackage

// File: rtl/text_buffer_writer_if.sv
// Character input handshake plus the pixel-encoder read port.
interface text_buffer_writer_if;
  import text_pkg::*;

  logic  in_valid;
  char_t in_char;
  logic  in_ready;
  row_t  rd_row;
  col_t  rd_col;
  char_t rd_char;

  modport master (output in_valid, in_char, rd_row, rd_col,
                  input  in_ready, rd_char);
  modport slave  (input  in_valid, in_char, rd_row, rd_col,
                  output in_ready, rd_char);
endinterface

// File: rtl/text_ram.sv
// Character grid storage: one synchronous write port, one asynchronous read port.
module text_ram
  import text_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  addr_t waddr,
  input  char_t wdata,
  input  addr_t raddr,
  output char_t rdata
);

  char_t mem [ROW_NUMBER*COL_NUMBER];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/text_buffer_writer.sv
// Text-mode writer: cursor handling, clears and ring-buffer scroll over a 16x32 grid.
module text_buffer_writer
  import text_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  text_buffer_writer_if.slave  bus,
  output row_t                 cursor_row,
  output col_t                 cursor_col,
  output logic                 busy
);

  state_t state;
  addr_t  clr_cnt;
  row_t   top_row;
  row_t   clr_row;
  logic   in_ready_q;

  logic   take;
  logic   printable;
  logic   at_origin;
  logic   adv_row;
  row_t   bs_row;
  col_t   bs_col;
  row_t   wr_row;
  col_t   wr_col;
  row_t   rd_phys_row;
  logic   we;
  addr_t  waddr;
  char_t  wdata;

  assign bus.in_ready = in_ready_q;
  assign take         = bus.in_valid & in_ready_q;
  assign printable    = is_printable(bus.in_char);
  assign at_origin    = (cursor_row == '0) && (cursor_col == '0);
  assign adv_row      = take && (state == IDLE) &&
                        ((bus.in_char == CC_LF) ||
                         (printable && (cursor_col == COL_BIT_LEN'(COL_NUMBER-1))));
  assign rd_phys_row  = bus.rd_row + top_row;

  // Write-port steering: clears own the port while busy, accepted chars otherwise.
  always_comb begin
    we     = 1'b0;
    waddr  = '0;
    wdata  = BLANK_ID;
    bs_row = cursor_row;
    bs_col = cursor_col - COL_BIT_LEN'(1);
    if (cursor_col == '0) begin
      bs_row = cursor_row - ROW_BIT_LEN'(1);
      bs_col = COL_BIT_LEN'(COL_NUMBER-1);
    end
    wr_row = cursor_row + top_row;
    wr_col = cursor_col;
    unique case (state)
      CLEAR_ALL: begin
        we    = 1'b1;
        waddr = clr_cnt;
      end
      CLEAR_ROW: begin
        we    = 1'b1;
        waddr = {clr_row, clr_cnt[COL_BIT_LEN-1:0]};
      end
      IDLE: begin
        if (take && (bus.in_char == CC_BS)) begin
          we     = ~at_origin;
          wr_row = bs_row + top_row;
          wr_col = bs_col;
        end else if (take && printable) begin
          we    = 1'b1;
          wdata = bus.in_char;
        end
        waddr = {wr_row, wr_col};
      end
      default: ;
    endcase
  end

  text_ram u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr ({rd_phys_row, bus.rd_col}),
    .rdata (bus.rd_char)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR_ALL;
      clr_cnt    <= '0;
      clr_row    <= '0;
      top_row    <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      in_ready_q <= 1'b0;
      busy       <= 1'b1;
    end else begin
      unique case (state)
        CLEAR_ALL: begin
          clr_cnt <= clr_cnt + ADDR_LEN'(1);
          if (clr_cnt == ADDR_LEN'(ROW_NUMBER*COL_NUMBER-1)) begin
            state      <= IDLE;
            in_ready_q <= 1'b1;
            busy       <= 1'b0;
          end
        end
        CLEAR_ROW: begin
          clr_cnt <= clr_cnt + ADDR_LEN'(1);
          if (clr_cnt[COL_BIT_LEN-1:0] == COL_BIT_LEN'(COL_NUMBER-1)) begin
            clr_cnt    <= '0;
            state      <= IDLE;
            in_ready_q <= 1'b1;
            busy       <= 1'b0;
          end
        end
        IDLE: begin
          if (take) begin
            case (bus.in_char)
              CC_FF: begin
                top_row    <= '0;
                cursor_row <= '0;
                cursor_col <= '0;
                clr_cnt    <= '0;
                state      <= CLEAR_ALL;
                in_ready_q <= 1'b0;
                busy       <= 1'b1;
              end
              CC_CR, CC_LF: cursor_col <= '0;
              CC_BS: begin
                if (!at_origin) begin
                  cursor_row <= bs_row;
                  cursor_col <= bs_col;
                end
              end
              default: begin
                if (printable) cursor_col <= cursor_col + COL_BIT_LEN'(1);
              end
            endcase
            // Leaving the bottom line rotates the ring and blanks the reused row.
            if (adv_row) begin
              if (cursor_row != ROW_BIT_LEN'(ROW_NUMBER-1)) begin
                cursor_row <= cursor_row + ROW_BIT_LEN'(1);
              end else begin
                top_row    <= top_row + ROW_BIT_LEN'(1);
                clr_row    <= top_row;
                clr_cnt    <= '0;
                state      <= CLEAR_ROW;
                in_ready_q <= 1'b0;
                busy       <= 1'b1;
              end
            end
          end
        end
        default: state <= CLEAR_ALL;
      endcase
    end
  end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed self-checking bench for text_buffer_writer.
module tb_text_buffer_writer;
  import text_pkg::*;

  logic clk;
  logic reset;
  row_t cursor_row;
  col_t cursor_col;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;

  text_buffer_writer_if bus ();

  text_buffer_writer dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Count negedges with in_ready low, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset(output int n);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_busy(n);
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    @(negedge clk);
    count_busy(n);
    if (n >= 2000) check("send_timeout", 32'(n), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic rd_check(input string tag, input int r, input int c, input logic [7:0] exp);
    bus.rd_row = 4'(r);
    bus.rd_col = 5'(c);
    #1;
    check(tag, 32'(bus.rd_char), 32'(exp));
  endtask

  task automatic cursor_check(input string tag, input int r, input int c);
    check({tag, "_row"}, 32'(cursor_row), 32'(r));
    check({tag, "_col"}, 32'(cursor_col), 32'(c));
  endtask

  // Cells in rows r0..r1 that equal v (eq=1) or differ from v (eq=0).
  task automatic count_cells(input logic [7:0] v, input bit eq, input int r0, input int r1,
                             output int n);
    n = 0;
    for (int r = r0; r <= r1; r++) begin
      for (int c = 0; c < 32; c++) begin
        bus.rd_row = 4'(r);
        bus.rd_col = 5'(c);
        #1;
        if ((bus.rd_char == v) == eq) n++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_char  = '0;
    bus.rd_row   = '0;
    bus.rd_col   = '0;

    // 1: power-up clear
    do_reset(n);
    check("reset_busy_cycles", 32'(n), 32'd512);
    check("reset_busy_flag", 32'(busy), 32'd0);
    cursor_check("reset_cursor", 0, 0);
    count_cells(8'd32, 1'b0, 0, 15, n);
    check("reset_nonblank", 32'(n), 32'd0);

    // 2: two chars, then same-cycle read sees the old value
    send(8'd65);
    send(8'd66);
    rd_check("t2_00", 0, 0, 8'd65);
    rd_check("t2_01", 0, 1, 8'd66);
    cursor_check("t2_cursor", 0, 2);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_char  = 8'd67;
    rd_check("t2_same_cycle_old", 0, 2, 8'd32);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rd_check("t2_next_cycle_new", 0, 2, 8'd67);
    cursor_check("t2_cursor3", 0, 3);

    // 3: line wrap and backspace across the wrap
    do_reset(n);
    check("t3_reset_busy", 32'(n), 32'd512);
    for (int i = 0; i < 33; i++) send(8'(33 + i));
    rd_check("t3_10", 1, 0, 8'd65);
    rd_check("t3_031", 0, 31, 8'd64);
    cursor_check("t3_cursor", 1, 1);
    send(CC_BS);
    rd_check("t3_bs1", 1, 0, 8'd32);
    cursor_check("t3_bs1_cursor", 1, 0);
    send(CC_BS);
    rd_check("t3_bs2", 0, 31, 8'd32);
    rd_check("t3_030", 0, 30, 8'd63);
    cursor_check("t3_bs2_cursor", 0, 31);

    // 4: scroll via LF, then scroll via wrap at the bottom-right cell
    send(CC_FF);
    count_busy(n);
    check("t4_ff_busy", 32'(n), 32'd512);
    send(8'd88);
    rd_check("t4_x", 0, 0, 8'd88);
    for (int i = 0; i < 15; i++) send(CC_LF);
    cursor_check("t4_lf15", 15, 0);
    send(CC_LF);
    count_busy(n);
    check("t4_scroll_busy", 32'(n), 32'd32);
    cursor_check("t4_scroll_cursor", 15, 0);
    count_cells(8'd88, 1'b1, 0, 15, n);
    check("t4_x_gone", 32'(n), 32'd0);
    count_cells(8'd32, 1'b0, 15, 15, n);
    check("t4_row15_blank", 32'(n), 32'd0);
    for (int i = 0; i < 31; i++) send(8'd97);
    cursor_check("t4_row_fill", 15, 31);
    send(8'd98);
    count_busy(n);
    check("t4_wrap_scroll_busy", 32'(n), 32'd32);
    rd_check("t4_wrap_last", 14, 31, 8'd98);
    rd_check("t4_wrap_first", 14, 0, 8'd97);
    count_cells(8'd32, 1'b0, 15, 15, n);
    check("t4_wrap_row15_blank", 32'(n), 32'd0);
    cursor_check("t4_wrap_cursor", 15, 0);

    // 5: form feed mid-text, undrawable id, backspace at origin, CR
    send(CC_FF);
    count_busy(n);
    check("t5_ff_busy", 32'(n), 32'd512);
    count_cells(8'd32, 1'b0, 0, 15, n);
    check("t5_all_blank", 32'(n), 32'd0);
    cursor_check("t5_ff_cursor", 0, 0);
    send(8'd200);
    @(negedge clk);
    check("t5_200_ready", 32'(bus.in_ready), 32'd1);
    rd_check("t5_200_cell", 0, 0, 8'd32);
    cursor_check("t5_200_cursor", 0, 0);
    send(CC_BS);
    rd_check("t5_bs_cell", 0, 0, 8'd32);
    cursor_check("t5_bs_cursor", 0, 0);
    send(8'd65);
    send(8'd66);
    send(CC_CR);
    cursor_check("t5_cr_cursor", 0, 0);
    send(8'd67);
    rd_check("t5_cr_overwrite", 0, 0, 8'd67);
    rd_check("t5_cr_keep", 0, 1, 8'd66);

    // 6: reset during row clear, input held valid while busy
    for (int i = 0; i < 15; i++) send(CC_LF);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_char  = CC_LF;
    @(negedge clk);
    bus.in_char  = 8'd90;
    repeat (5) @(negedge clk);
    check("t6_in_clear_row", 32'(bus.in_ready), 32'd0);
    cursor_check("t6_pre_reset_cursor", 15, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_busy(n);
    bus.in_valid = 1'b0;
    check("t6_restart_busy", 32'(n), 32'd512);
    cursor_check("t6_cursor", 0, 0);
    count_cells(8'd32, 1'b0, 0, 15, n);
    check("t6_all_blank", 32'(n), 32'd0);
    send(8'd70);
    rd_check("t6_after_write", 0, 0, 8'd70);
    cursor_check("t6_after_cursor", 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
